// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared instruction-format codes and immediate range helper
// Used by both the immediate packer and the control unit's sign-extender.
package cpu_pkg;

   localparam int XLEN      = 32;
   localparam int FMT_WIDTH = 3;

   typedef enum logic [FMT_WIDTH-1:0] {
      Imm      = 3'd0,
      UpperImm = 3'd1,
      Store    = 3'd2,
      Branch   = 3'd3,
      Jump     = 3'd4
   } instr_format;

   // True when v[XLEN-1:lsb] are all equal, i.e. v survives truncation to lsb+1 signed bits.
   function automatic logic fits_above(input logic [XLEN-1:0] v, input int unsigned lsb);
      logic [XLEN-1:0] s;
      s = $signed(v) >>> lsb;
      return (s == '0) || (s == '1);
   endfunction

endpackage

// File: rtl/instr_packer_if.sv
// rtl/instr_packer_if.sv - input/output handshake bundle of the instruction packer
interface instr_packer_if #(
   parameter int DATA_WIDTH = 32,
   parameter int IMM_WIDTH  = 3,
   parameter int ADDR_WIDTH = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [IMM_WIDTH-1:0]  fmt;
   logic [DATA_WIDTH-1:0] imm;
   logic [DATA_WIDTH-1:0] base;
   logic                  clear;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] instr;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  out_err;
   logic                  err_any;

   modport master (
      output in_valid, fmt, imm, base, clear, out_ready,
      input  in_ready, out_valid, instr, addr, out_err, err_any
   );

   modport slave (
      input  in_valid, fmt, imm, base, clear, out_ready,
      output in_ready, out_valid, instr, addr, out_err, err_any
   );

endinterface

// File: rtl/imm_pack.sv
// rtl/imm_pack.sv - scatters an immediate into the bit positions of its format
// Inverse of the sign-extender; bits that do not fit are dropped and flagged.
module imm_pack
   import cpu_pkg::*;
(
   input  logic [XLEN-1:0]      base,
   input  logic [XLEN-1:0]      imm,
   input  logic [FMT_WIDTH-1:0] fmt,
   output logic [XLEN-1:0]      word,
   output logic                 err
);

   always_comb begin
      word = base;
      err  = 1'b0;
      case (instr_format'(fmt))
         UpperImm: begin
            word[31:20] = imm[31:20];
            err         = |imm[19:0];
         end
         Store: begin
            word[31:25] = imm[11:5];
            word[11:7]  = imm[4:0];
            err         = !fits_above(imm, 11);
         end
         Branch: begin
            word[31]    = imm[12];
            word[30:25] = imm[10:5];
            word[11:8]  = imm[4:1];
            word[7]     = imm[11];
            err         = !fits_above(imm, 12) || imm[0];
         end
         Jump: begin
            word[31]    = imm[20];
            word[30:21] = imm[10:1];
            word[20]    = imm[11];
            word[19:12] = imm[19:12];
            err         = !fits_above(imm, 20) || imm[0];
         end
         // Codes 5-7 fall back to the plain I-type layout.
         default: begin
            word[31:20] = imm[11:0];
            err         = !fits_above(imm, 11);
         end
      endcase
   end

endmodule

// File: rtl/instr_packer.sv
// rtl/instr_packer.sv - registered immediate-packing encoder with word-address tagging
// One output register stage, full-throughput handshake, sticky error flag.
module instr_packer
   import cpu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int IMM_WIDTH  = 3,
   parameter int ADDR_WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst,
   instr_packer_if.slave  bus
);

   logic                  in_fire;
   logic                  out_fire;
   logic [IMM_WIDTH-1:0]  fmt_in;
   logic [DATA_WIDTH-1:0] pk_word;
   logic                  pk_err;

   logic                  out_valid_q;
   logic [DATA_WIDTH-1:0] instr_q;
   logic                  out_err_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  err_any_q;

   assign fmt_in   = bus.fmt;
   assign in_fire  = bus.in_valid && bus.in_ready;
   assign out_fire = out_valid_q && bus.out_ready;

   imm_pack u_imm_pack (
      .base (bus.base),
      .imm  (bus.imm),
      .fmt  (fmt_in),
      .word (pk_word),
      .err  (pk_err)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         instr_q     <= '0;
         out_err_q   <= 1'b0;
      end else if (in_fire) begin
         out_valid_q <= 1'b1;
         instr_q     <= pk_word;
         out_err_q   <= pk_err;
      end else if (out_fire) begin
         out_valid_q <= 1'b0;
      end
   end

   // clear beats the handshake increment on addr, but a new error beats clear on err_any.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q    <= '0;
         err_any_q <= 1'b0;
      end else begin
         if (bus.clear) begin
            addr_q <= '0;
         end else if (out_fire) begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
         end
         if (in_fire && pk_err) begin
            err_any_q <= 1'b1;
         end else if (bus.clear) begin
            err_any_q <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = !out_valid_q || bus.out_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.instr     = instr_q;
   assign bus.out_err   = out_err_q;
   assign bus.addr      = addr_q;
   assign bus.err_any   = err_any_q;

endmodule

// File: tb/tb_instr_packer.sv
// tb/tb_instr_packer.sv - randomized and directed checks of instr_packer against a bit-map model
module tb_instr_packer;

   localparam int AW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   bit          mv;
   logic [31:0] m_instr;
   bit          m_err;
   int          m_addr;
   bit          m_err_any;

   instr_packer_if #(.DATA_WIDTH(32), .IMM_WIDTH(3), .ADDR_WIDTH(AW)) ifc ();

   instr_packer #(.DATA_WIDTH(32), .IMM_WIDTH(3), .ADDR_WIDTH(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Which immediate bit lands in instruction bit i, or -1 when base passes through.
   function automatic int src_bit(input int f, input int i);
      case (f)
         1: return (i >= 20) ? i : -1;
         2: begin
            if (i >= 25) return i - 20;
            if (i >= 7 && i <= 11) return i - 7;
            return -1;
         end
         3: begin
            if (i == 31) return 12;
            if (i == 7) return 11;
            if (i >= 25) return i - 20;
            if (i >= 8 && i <= 11) return i - 7;
            return -1;
         end
         4: begin
            if (i == 31) return 20;
            if (i == 20) return 11;
            if (i >= 21) return i - 20;
            if (i >= 12 && i <= 19) return i;
            return -1;
         end
         default: return (i >= 20) ? i - 20 : -1;
      endcase
   endfunction

   function automatic logic [31:0] model_instr(input int f, input logic [31:0] im, input logic [31:0] b);
      logic [31:0] r;
      int          s;
      for (int i = 0; i < 32; i++) begin
         s    = src_bit(f, i);
         r[i] = (s < 0) ? b[i] : im[s];
      end
      return r;
   endfunction

   function automatic bit model_err(input int f, input logic [31:0] im);
      longint v;
      v = longint'($signed(im));
      case (f)
         1: return (longint'(im) % 1048576) != 0;
         2: return (v < -2048) || (v > 2047);
         3: return (v < -4096) || (v > 4095) || (v % 2 != 0);
         4: return (v < -1048576) || (v > 1048575) || (v % 2 != 0);
         default: return (v < -2048) || (v > 2047);
      endcase
   endfunction

   function automatic logic [31:0] rand_imm();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 3))
         0: return r;
         1: return $signed(r) >>> 19;
         2: return $signed(r) >>> 11;
         default: return r & 32'hFFF0_0000;
      endcase
   endfunction

   task automatic check_outputs();
      check("out_valid", ifc.out_valid, mv);
      check("addr", ifc.addr, 64'(m_addr));
      check("err_any", ifc.err_any, m_err_any);
      if (mv) begin
         check("instr", ifc.instr, m_instr);
         check("out_err", ifc.out_err, m_err);
      end
   endtask

   task automatic step(input bit iv, input int f, input logic [31:0] im, input logic [31:0] b,
                       input bit clr, input bit ordy);
      bit in_fire;
      bit out_fire;
      @(negedge clk);
      check_outputs();
      ifc.in_valid  = iv;
      ifc.fmt       = 3'(f);
      ifc.imm       = im;
      ifc.base      = b;
      ifc.clear     = clr;
      ifc.out_ready = ordy;
      #1;
      check("in_ready", ifc.in_ready, !mv || ordy);
      in_fire  = iv && (!mv || ordy);
      out_fire = mv && ordy;
      if (clr) m_addr = 0;
      else if (out_fire) m_addr = (m_addr + 1) % (1 << AW);
      if (in_fire && model_err(f, im)) m_err_any = 1;
      else if (clr) m_err_any = 0;
      if (in_fire) begin
         mv      = 1;
         m_instr = model_instr(f, im, b);
         m_err   = model_err(f, im);
      end else if (out_fire) begin
         mv = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      mv        = 0;
      m_instr   = '0;
      m_err     = 0;
      m_addr    = 0;
      m_err_any = 0;
   endtask

   task automatic mid_reset();
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("rst_out_valid", ifc.out_valid, 0);
      check("rst_addr", ifc.addr, 0);
      check("rst_err_any", ifc.err_any, 0);
      check("rst_in_ready", ifc.in_ready, 1);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      ifc.in_valid  = 1'b0;
      ifc.fmt       = '0;
      ifc.imm       = '0;
      ifc.base      = '0;
      ifc.clear     = 1'b0;
      ifc.out_ready = 1'b0;
      model_reset();
      #1;
      check("in_ready_in_reset", ifc.in_ready, 1);
      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", ifc.out_valid, 0);
      check("reset_instr", ifc.instr, 0);
      check("reset_addr", ifc.addr, 0);
      check("reset_out_err", ifc.out_err, 0);
      check("reset_err_any", ifc.err_any, 0);
      @(negedge clk);
      rst = 1'b0;

      step(1, 0, 32'hFFFF_FFFF, 32'h0000_0013, 0, 0);
      check("imm_instr", ifc.instr, 32'hFFF0_0013);
      check("imm_err", ifc.out_err, 0);
      check("imm_addr", ifc.addr, 0);
      check("imm_valid", ifc.out_valid, 1);

      step(1, 2, 32'h0000_0024, 32'h0011_2023, 0, 1);
      check("store_instr", ifc.instr, 32'h0211_2223);
      check("store_err", ifc.out_err, 0);
      check("store_addr", ifc.addr, 1);

      step(1, 3, 32'h0000_0003, 32'h0000_0063, 0, 1);
      check("branch_err", ifc.out_err, 1);
      check("branch_11_8", 64'(ifc.instr[11:8]), 1);
      check("branch_err_any", ifc.err_any, 1);

      step(1, 4, 32'h0010_0000, 32'h0000_006F, 0, 1);
      check("jump_err", ifc.out_err, 1);

      step(1, 0, 32'h0000_0005, 32'h0000_0013, 0, 1);
      check("ok_after_err", ifc.out_err, 0);
      check("err_any_sticky", ifc.err_any, 1);

      step(0, 0, 0, 0, 1, 0);
      check("clear_err_any", ifc.err_any, 0);
      check("clear_addr", ifc.addr, 0);

      step(1, 0, 32'h0000_07FF, 32'h0000_0093, 0, 1);
      for (int k = 0; k < 3; k++) begin
         step(1, 1, 32'hABCD_E000, 32'h0000_0037, 0, 0);
         check("bp_instr", ifc.instr, 32'h7FF0_0093);
         check("bp_addr", ifc.addr, 1);
         check("bp_valid", ifc.out_valid, 1);
         check("bp_in_ready", ifc.in_ready, 0);
      end
      step(1, 1, 32'h1230_0000, 32'h0000_0037, 0, 1);
      check("bp_release_instr", ifc.instr, 32'h1230_0037);
      check("bp_release_addr", ifc.addr, 2);

      step(0, 0, 0, 0, 1, 1);
      for (int k = 0; k < 17; k++) begin
         step(1, $urandom_range(0, 7), rand_imm(), $urandom, 0, 1);
         check("wrap_addr", ifc.addr, 64'(k % 16));
      end

      step(1, 0, 32'h0000_0001, 32'h0000_0013, 1, 1);
      check("clear_mid_addr", ifc.addr, 0);
      step(1, 3, 32'h0000_0001, 32'h0000_0063, 1, 1);
      check("clear_vs_err", ifc.err_any, 1);

      mid_reset();
      step(1, 0, 32'h0000_0001, 32'h0000_0013, 0, 1);
      check("resume_valid", ifc.out_valid, 1);
      check("resume_addr", ifc.addr, 0);
      check("resume_instr", ifc.instr, 32'h0010_0013);

      for (int k = 0; k < 600; k++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 7), rand_imm(), $urandom,
              $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
      end
      step(0, 0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
